// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t       : controller state encoding (IDLE, RUN, DONE)
//   DEFAULT_WIDTH : default operand/result width in bits
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/half_subtractor.sv
// One-bit half subtractor: Dif = X - Y, Bor = borrow out.
//   X   : minuend bit
//   Y   : subtrahend bit
//   Dif : difference bit
//   Bor : borrow generated when X=0 and Y=1
module half_subtractor (
  input  logic X,
  input  logic Y,
  output logic Dif,
  output logic Bor
);

  assign Dif = X ^ Y;
  assign Bor = ~X & Y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, D = A - B, one bit per clock, LSB first.
// A Start request in IDLE or DONE latches the operands. WIDTH RUN cycles
// follow, then a single DONE cycle in which D and Bout are valid.
//   CLK   : rising-edge clock
//   Reset : asynchronous active-high reset, clears all state
//   Start : level-sensitive request, ignored while Busy
//   A, B  : minuend / subtrahend, sampled on the accepting edge only
//   Busy  : high while the subtraction runs
//   Done  : one-cycle pulse, result valid
//   D     : difference (A - B) mod 2^WIDTH, held until the next operation
//   Bout  : final borrow, 1 iff A < B
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] ra, rb, d_reg;
  logic [CW-1:0]    count;
  logic             borrow;
  logic             load;

  // Full-subtractor bit cell: two half subtractors plus the borrow OR.
  logic hs1_dif, hs1_bor, bit_d, hs2_bor, bit_borrow;

  half_subtractor u_hs1 (
    .X   (ra[0]),
    .Y   (rb[0]),
    .Dif (hs1_dif),
    .Bor (hs1_bor)
  );

  half_subtractor u_hs2 (
    .X   (hs1_dif),
    .Y   (borrow),
    .Dif (bit_d),
    .Bor (hs2_bor)
  );

  assign bit_borrow = hs1_bor | hs2_bor;

  // Next-state logic. A new operation may start from IDLE or straight out
  // of DONE, so Start held high gives back-to-back runs.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (count == LAST) state_next = DONE;
      end
      DONE: begin
        if (Start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      ra     <= '0;
      rb     <= '0;
      d_reg  <= '0;
      count  <= '0;
      borrow <= 1'b0;
    end else begin
      state <= state_next;
      if (load) begin
        ra     <= A;
        rb     <= B;
        borrow <= 1'b0;
        count  <= '0;
      end else if (state == RUN) begin
        ra     <= ra >> 1;
        rb     <= rb >> 1;
        borrow <= bit_borrow;
        // New bits enter at the MSB, so after WIDTH shifts bit 0 is the LSB.
        d_reg  <= {bit_d, d_reg[WIDTH-1:1]};
        // Saturate rather than wrap; the count is reloaded on the next Start.
        if (count != LAST) count <= count + 1'b1;
      end
    end
  end

  // All outputs are decodes of registers only.
  assign Busy = (state == RUN);
  assign Done = (state == DONE);
  assign D    = d_reg;
  assign Bout = borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start8, busy8, done8, bout8;
  logic [7:0] a8, b8, d8;
  logic       start4, busy4, done4, bout4;
  logic [3:0] a4, b4, d4;

  int n_tests = 0;
  int n_fail  = 0;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .CLK(clk), .Reset(rst), .Start(start8), .A(a8), .B(b8),
    .Busy(busy8), .Done(done8), .D(d8), .Bout(bout8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .CLK(clk), .Reset(rst), .Start(start4), .A(a4), .B(b4),
    .Busy(busy4), .Done(done4), .D(d4), .Bout(bout4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       bout;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 8-bit operation from IDLE with full handshake timing checks.
  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] exp_d, input logic exp_b, input string name);
    int cyc;
    int busy_bad;
    a8 = a; b8 = b; start8 = 1'b1;
    tick();                       // edge 0 accepts
    start8 = 1'b0;
    cyc = 0;
    busy_bad = 0;
    while (!done8 && cyc < 30) begin
      if (!busy8) busy_bad++;
      tick();
      cyc++;
    end
    check({name, "_latency"}, cyc, 8);
    check({name, "_busy_window"}, busy_bad, 0);
    check({name, "_busy_at_done"}, int'(busy8), 0);
    check({name, "_d"}, int'(d8), int'(exp_d));
    check({name, "_bout"}, int'(bout8), int'(exp_b));
    tick();
    check({name, "_done_width"}, int'(done8), 0);
    tick();
    check({name, "_d_hold"}, int'(d8), int'(exp_d));
    $display("[TB] %s: A=%02h B=%02h -> D=%02h Bout=%0d", name, a, b, d8, bout8);
  endtask

  // One 4-bit operation from IDLE.
  task automatic run4(input logic [3:0] a, input logic [3:0] b);
    int cyc;
    int exp_d;
    a4 = a; b4 = b; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    cyc = 0;
    while (!done4 && cyc < 20) begin
      tick();
      cyc++;
    end
    exp_d = ((int'(a) - int'(b)) % 16 + 16) % 16;
    check("w4_latency", cyc, 4);
    check("w4_d", int'(d4), exp_d);
    check("w4_bout", int'(bout4), (int'(a) < int'(b)) ? 1 : 0);
    tick();
  endtask

  initial begin
    vec_t tbl[6];
    int   cyc, t1, t2, dones, exp_d;
    logic [7:0] ra, rb;

    tbl[0] = '{a: 8'h05, b: 8'h03, d: 8'h02, bout: 1'b0};
    tbl[1] = '{a: 8'h03, b: 8'h05, d: 8'hFE, bout: 1'b1};
    tbl[2] = '{a: 8'h00, b: 8'hFF, d: 8'h01, bout: 1'b1};
    tbl[3] = '{a: 8'hFF, b: 8'hFF, d: 8'h00, bout: 1'b0};
    tbl[4] = '{a: 8'hFF, b: 8'h00, d: 8'hFF, bout: 1'b0};
    tbl[5] = '{a: 8'h00, b: 8'h01, d: 8'hFF, bout: 1'b1};

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    tick();
    tick();
    check("reset_busy", int'(busy8), 0);
    check("reset_done", int'(done8), 0);
    check("reset_d", int'(d8), 0);
    check("reset_bout", int'(bout8), 0);
    check("reset_busy4", int'(busy4), 0);
    check("reset_d4", int'(d4), 0);
    rst = 1'b0;
    tick();

    // Directed table
    for (int i = 0; i < 6; i++) begin
      run8(tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].bout, $sformatf("vec%0d", i));
    end

    // Start re-pulsed mid-run must be ignored
    a8 = 8'h05; b8 = 8'h03; start8 = 1'b1;
    tick();                       // edge 0
    start8 = 1'b0;
    tick();                       // edge 1
    tick();                       // edge 2
    a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
    tick();                       // edge 3 samples the ignored request
    start8 = 1'b0;
    cyc = 3;
    while (!done8 && cyc < 30) begin
      tick();
      cyc++;
    end
    check("ignore_latency", cyc, 8);
    check("ignore_d", int'(d8), 8'h02);
    check("ignore_bout", int'(bout8), 0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8) dones++;
    end
    check("ignore_no_second_done", dones, 0);
    $display("[TB] ignore_start: D=%02h Bout=%0d extra_dones=%0d", d8, bout8, dones);

    // Reset asserted during a run
    a8 = 8'hF0; b8 = 8'h0F; start8 = 1'b1;
    tick();                       // edge 0
    start8 = 1'b0;
    tick(); tick(); tick();       // edges 1..3
    @(posedge clk);               // edge 4
    rst = 1'b1;
    #1;
    check("midreset_busy", int'(busy8), 0);
    check("midreset_d", int'(d8), 0);
    check("midreset_bout", int'(bout8), 0);
    check("midreset_done", int'(done8), 0);
    tick();
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8) dones++;
    end
    check("midreset_no_done", dones, 0);
    $display("[TB] mid_reset: Busy=%0d D=%02h dones_after=%0d", busy8, d8, dones);
    run8(8'h05, 8'h03, 8'h02, 1'b0, "after_reset");

    // Start held high: back-to-back operations
    a8 = 8'h80; b8 = 8'h01; start8 = 1'b1;
    tick();                       // edge 0
    a8 = 8'h01; b8 = 8'h02;       // picked up by the DONE-state accept
    cyc = 0;
    while (!done8 && cyc < 30) begin
      tick();
      cyc++;
    end
    t1 = cyc;
    check("b2b_first_latency", t1, 8);
    check("b2b_first_d", int'(d8), 8'h7F);
    check("b2b_first_bout", int'(bout8), 0);
    tick();
    cyc++;
    check("b2b_done_width", int'(done8), 0);
    check("b2b_no_idle", int'(busy8), 1);
    start8 = 1'b0;
    while (!done8 && cyc < 60) begin
      tick();
      cyc++;
    end
    t2 = cyc;
    check("b2b_spacing", t2 - t1, 9);
    check("b2b_second_d", int'(d8), 8'hFF);
    check("b2b_second_bout", int'(bout8), 1);
    tick();
    check("b2b_second_done_width", int'(done8), 0);
    $display("[TB] back_to_back: done at %0d and %0d, D=%02h Bout=%0d", t1, t2, d8, bout8);

    // Random operands against arithmetic model
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      exp_d = (int'(ra) - int'(rb) + 256) % 256;
      run8(ra, rb, 8'(exp_d), (ra < rb), $sformatf("rand%0d", i));
    end

    // Exhaustive 4-bit
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        run4(4'(x), 4'(y));
      end
      $display("[TB] w4 A=%0h all B done, last D=%0h Bout=%0d", x, d4, bout4);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
